// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared element/word types and constants for the sorter front end
package sort_pkg;

  localparam int ELEM_W = 4;
  localparam int N_ELEM = 4;

  typedef logic [ELEM_W-1:0]          elem_t;
  typedef logic [N_ELEM*ELEM_W-1:0]   word_t;
  typedef logic [$clog2(N_ELEM+1)-1:0] cnt_t;

  typedef enum logic {FILL, FULL} pack_state_t;

  // All-ones pads sort to the top of an ascending network
  localparam elem_t PAD_DEFAULT = 4'hF;

endpackage

// File: rtl/nibble_packer_pad_fill.sv
// rtl/nibble_packer_pad_fill.sv - replaces every slot above the last real index with PAD
module pad_fill
  import sort_pkg::*;
#(
  parameter int             N     = N_ELEM,
  parameter int             W     = ELEM_W,
  parameter logic [W-1:0]   PAD   = PAD_DEFAULT,
  parameter int             IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N*W-1:0]   i_word,
  input  logic [IDX_W-1:0] i_last_idx,
  output logic [N*W-1:0]   o_word
);

  always_comb begin
    o_word = i_word;
    for (int k = 0; k < N; k++) begin
      if (k > int'(i_last_idx)) o_word[k*W +: W] = PAD;
    end
  end

endmodule

// File: rtl/nibble_packer.sv
// rtl/nibble_packer.sv - gathers N elements per word, pads short groups, holds word until consumed
module nibble_packer
  import sort_pkg::*;
#(
  parameter int           N   = N_ELEM,
  parameter int           W   = ELEM_W,
  parameter logic [W-1:0] PAD = PAD_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [W-1:0]           in_data,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*W-1:0]         out_data,
  output logic [$clog2(N+1)-1:0] out_cnt
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(N + 1);

  pack_state_t      r_state, w_next_state;
  logic [IDX_W-1:0] r_idx, w_next_idx, w_slot;
  logic [N*W-1:0]   r_word, w_written, w_padded;
  logic [CNT_W-1:0] r_cnt;
  logic             w_elem_xfer, w_word_xfer, w_complete;

  // The held word and the slots being filled share one register; a drain frees it on the same edge
  assign w_elem_xfer = in_valid && in_ready;
  assign w_word_xfer = out_valid && out_ready;
  assign w_slot      = (r_state == FULL) ? '0 : r_idx;
  assign w_complete  = w_elem_xfer && (in_last || (w_slot == IDX_W'(N - 1)));

  always_comb begin
    w_written = r_word;
    w_written[int'(w_slot)*W +: W] = in_data;
  end

  pad_fill #(.N(N), .W(W), .PAD(PAD), .IDX_W(IDX_W)) u_pad_fill (
    .i_word     (w_written),
    .i_last_idx (w_slot),
    .o_word     (w_padded)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
      r_idx   <= '0;
      r_word  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
      if (w_elem_xfer) r_word <= w_complete ? w_padded : w_written;
      if (w_complete)  r_cnt  <= CNT_W'(w_slot) + CNT_W'(1);
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    if (w_elem_xfer) begin
      if (w_complete) begin
        w_next_state = FULL;
        w_next_idx   = '0;
      end else begin
        w_next_state = FILL;
        w_next_idx   = w_slot + 1'b1;
      end
    end else if (w_word_xfer) begin
      w_next_state = FILL;
      w_next_idx   = '0;
    end
  end

  always_comb begin
    out_valid = (r_state == FULL);
    in_ready  = (r_state == FILL) ? 1'b1 : out_ready;
  end

  assign out_data = r_word;
  assign out_cnt  = r_cnt;

endmodule

// File: tb/tb_nibble_packer.sv
// tb/tb_nibble_packer.sv - directed and randomized checks of nibble_packer against a group-level model
module tb_nibble_packer;
  import sort_pkg::*;

  localparam int N = N_ELEM;
  localparam int W = ELEM_W;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, out_ready;
  logic [3:0]  in_data;
  logic        in_ready, out_valid;
  logic [15:0] out_data;
  logic [2:0]  out_cnt;

  int n_cmp = 0;
  int n_err = 0;

  bit          m_full;
  logic [15:0] m_word;
  int          m_cnt;
  logic [3:0]  m_grp[$];

  always #5 clk = ~clk;

  nibble_packer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt)
  );

  task automatic apply(input logic v, input logic [3:0] d, input logic l, input logic r);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    #1;
  endtask

  // Model: a group is a list of elements; a word is that list padded with F
  task automatic step();
    bit take;
    @(posedge clk);
    if (rst) begin
      m_full = 1'b0;
      m_grp.delete();
    end else begin
      take = in_valid && (!m_full || out_ready);
      if (m_full && out_ready) m_full = 1'b0;
      if (take) begin
        m_grp.push_back(in_data);
        if (in_last || m_grp.size() == N) begin
          m_word = 16'hFFFF;
          foreach (m_grp[i]) m_word[i*W +: W] = m_grp[i];
          m_cnt  = m_grp.size();
          m_full = 1'b1;
          m_grp.delete();
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    apply(1'b1, 4'h5, 1'b0, 1'b1);
    step();
    step();
    rst = 1'b0;
    apply(1'b0, 4'h0, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 16'h0) begin n_err++; $display("FAIL reset_data got %h want 0000", out_data); end
    n_cmp++; if (out_cnt !== 3'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", out_cnt); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", in_ready); end
  endtask

  task automatic test_full_group();
    logic [3:0] g1[4] = '{4'h3, 4'h1, 4'h4, 4'h2};
    logic [3:0] g2[4] = '{4'h5, 4'h9, 4'h2, 4'h6};
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, g1[i], 1'b0, 1'b1);
      step();
      if (i < 3) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_early_valid idx %0d got %b want 0", i, out_valid); end
      end
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL full_valid got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 16'h2413) begin n_err++; $display("FAIL full_data got %h want 2413", out_data); end
    n_cmp++; if (out_cnt !== 3'd4) begin n_err++; $display("FAIL full_cnt got %0d want 4", out_cnt); end
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, g2[i], 1'b0, 1'b1);
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready idx %0d got %b want 1", i, in_ready); end
      step();
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 16'h6295) begin n_err++; $display("FAIL b2b_data got %h want 6295", out_data); end
    n_cmp++; if (out_cnt !== 3'd4) begin n_err++; $display("FAIL b2b_cnt got %0d want 4", out_cnt); end
    apply(1'b0, 4'h0, 1'b0, 1'b1);
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid got %b want 0", out_valid); end
  endtask

  task automatic test_short_group();
    apply(1'b1, 4'h7, 1'b0, 1'b1); step();
    apply(1'b1, 4'h0, 1'b1, 1'b1); step();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL short_valid got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 16'hFF07) begin n_err++; $display("FAIL short_data got %h want ff07", out_data); end
    n_cmp++; if (out_cnt !== 3'd2) begin n_err++; $display("FAIL short_cnt got %0d want 2", out_cnt); end
    apply(1'b0, 4'h0, 1'b0, 1'b1); step();
    apply(1'b1, 4'h7, 1'b1, 1'b1); step();
    n_cmp++; if (out_data !== 16'hFFF7) begin n_err++; $display("FAIL single_data got %h want fff7", out_data); end
    n_cmp++; if (out_cnt !== 3'd1) begin n_err++; $display("FAIL single_cnt got %0d want 1", out_cnt); end
    apply(1'b0, 4'h0, 1'b1, 1'b1); step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL last_no_valid got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [3:0] g[4] = '{4'hA, 4'hB, 4'hC, 4'hD};
    logic [3:0] t[3] = '{4'h1, 4'h2, 4'h3};
    for (int i = 0; i < 4; i++) begin apply(1'b1, g[i], 1'b0, 1'b0); step(); end
    for (int c = 0; c < 5; c++) begin
      apply(1'b1, 4'hE, 1'b0, 1'b0);
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready cyc %0d got %b want 0", c, in_ready); end
      step();
      n_cmp++; if (out_data !== 16'hDCBA || out_valid !== 1'b1) begin
        n_err++; $display("FAIL bp_hold cyc %0d got %h/%b want dcba/1", c, out_data, out_valid);
      end
    end
    apply(1'b1, 4'hE, 1'b0, 1'b1);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
    for (int i = 0; i < 3; i++) begin apply(1'b1, t[i], 1'b0, 1'b1); step(); end
    n_cmp++; if (out_data !== 16'h321E) begin n_err++; $display("FAIL bp_slot0 got %h want 321e", out_data); end
    apply(1'b0, 4'h0, 1'b0, 1'b1); step();
  endtask

  task automatic test_drain_accept();
    logic [3:0] g[4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    for (int i = 0; i < 4; i++) begin apply(1'b1, g[i], 1'b0, 1'b0); step(); end
    n_cmp++; if (out_data !== 16'h1234) begin n_err++; $display("FAIL da_pre got %h want 1234", out_data); end
    apply(1'b1, 4'h8, 1'b1, 1'b1); step();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL da_valid got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 16'hFFF8) begin n_err++; $display("FAIL da_data got %h want fff8", out_data); end
    n_cmp++; if (out_cnt !== 3'd1) begin n_err++; $display("FAIL da_cnt got %0d want 1", out_cnt); end
    apply(1'b0, 4'h0, 1'b0, 1'b1); step();
  endtask

  task automatic test_reset_mid();
    logic [3:0] g[4] = '{4'h5, 4'h6, 4'h7, 4'h8};
    apply(1'b1, 4'h1, 1'b0, 1'b1); step();
    apply(1'b1, 4'h2, 1'b0, 1'b1); step();
    rst = 1'b1;
    apply(1'b1, 4'h9, 1'b1, 1'b1); step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid got %b want 0", out_valid); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, g[i], 1'b0, 1'b1); step();
      if (i < 3) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_early idx %0d got %b want 0", i, out_valid); end
      end
    end
    n_cmp++; if (out_data !== 16'h8765) begin n_err++; $display("FAIL rmid_data got %h want 8765", out_data); end
    n_cmp++; if (out_cnt !== 3'd4) begin n_err++; $display("FAIL rmid_cnt got %0d want 4", out_cnt); end
    apply(1'b0, 4'h0, 1'b0, 1'b1); step();
  endtask

  task automatic test_gapped();
    logic [3:0] g[4] = '{4'h9, 4'hA, 4'hB, 4'hC};
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, g[i], 1'b0, 1'b1); step();
      if (i < 3) begin
        for (int k = 0; k < 2; k++) begin
          n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL gap_valid idx %0d got %b want 0", i, out_valid); end
          apply(1'b0, 4'h0, 1'b0, 1'b1); step();
        end
      end
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL gap_done_valid got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 16'hCBA9) begin n_err++; $display("FAIL gap_data got %h want cba9", out_data); end
    apply(1'b0, 4'h0, 1'b0, 1'b1); step();
  endtask

  task automatic test_random();
    logic v, l, r;
    logic [3:0] d;
    for (int c = 0; c < 400; c++) begin
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 4) == 0);
      r = ($urandom_range(0, 2) != 0);
      d = 4'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      apply(v, d, l, r);
      n_cmp++; if (in_ready !== (!m_full || r)) begin n_err++; $display("FAIL rnd_ready cyc %0d got %b want %b", c, in_ready, !m_full || r); end
      n_cmp++; if (out_valid !== m_full) begin n_err++; $display("FAIL rnd_valid cyc %0d got %b want %b", c, out_valid, m_full); end
      if (m_full) begin
        n_cmp++; if (out_data !== m_word || out_cnt !== 3'(m_cnt)) begin
          n_err++; $display("FAIL rnd_word cyc %0d got %h/%0d want %h/%0d", c, out_data, out_cnt, m_word, m_cnt);
        end
      end
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_group();
    test_short_group();
    test_backpressure();
    test_drain_accept();
    test_reset_mid();
    test_gapped();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
